// File: rtl/hot_addr_pull.sv
// Consumer end of the hot-address ring: fetches 64 B lines over AXI4 read,
// filters entries by the per-line phase bit and streams valid PFNs out.
module hot_addr_pull #(
  parameter int unsigned RING_SIZE = 64 * 1024,
  parameter int unsigned ADDR_SIZE = 33
) (
  input  logic         axi4_mm_clk,
  input  logic         axi4_mm_rst,
  input  logic [63:0]  ring_base,
  input  logic [63:0]  ring_wr_count,
  output logic [63:0]  ring_rd_count,
  input  logic [5:0]   csr_aruser,
  output logic [11:0]  pull_arid,
  output logic [63:0]  pull_araddr,
  output logic [5:0]   pull_aruser,
  output logic         pull_arvalid,
  input  logic         pull_arready,
  input  logic [11:0]  pull_rid,
  input  logic [511:0] pull_rdata,
  input  logic [1:0]   pull_rresp,
  input  logic         pull_rlast,
  input  logic         pull_rvalid,
  output logic         pull_rready,
  output logic [31:0]  hot_pfn,
  output logic         hot_pfn_valid,
  input  logic         hot_pfn_ready,
  output logic [15:0]  stale_cnt,
  output logic [15:0]  rd_err_cnt
);

  localparam int unsigned LINES = RING_SIZE / 64;
  localparam int unsigned LB    = $clog2(LINES);

  typedef enum logic [1:0] {
    IDLE,
    AR,
    R,
    DRAIN
  } state_t;

  state_t         state;
  state_t         state_nx;
  logic [511:0]   line_buf;
  logic [3:0]     idx;
  logic [31:0]    entry;
  logic           phase_exp;
  logic           entry_live;
  logic           entry_stale;
  logic           advance;
  logic           have_work;
  logic [63:0]    line_off;
  logic           unused_ok;

  assign unused_ok = ^{pull_rid, pull_rlast, ADDR_SIZE[0]};

  // Line buffer shifts down one entry per advance, so the current entry is always the low word.
  assign entry       = line_buf[31:0];
  assign phase_exp   = ring_rd_count[0];
  assign entry_live  = (entry != '0) && (entry[31] == phase_exp);
  assign entry_stale = (entry != '0) && (entry[31] != phase_exp);
  assign advance     = (state == DRAIN) && (!entry_live || hot_pfn_ready);
  assign have_work   = (ring_base != '0) && (ring_wr_count > ring_rd_count);
  assign line_off    = {{(64 - LB - 6){1'b0}}, ring_rd_count[LB-1:0], 6'b0};

  assign pull_arid     = '0;
  assign pull_arvalid  = (state == AR);
  assign pull_rready   = (state == R);
  assign hot_pfn_valid = (state == DRAIN) && entry_live;
  assign hot_pfn       = hot_pfn_valid ? {1'b0, entry[30:0]} : '0;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (have_work) state_nx = AR;
      AR:      if (pull_arready) state_nx = R;
      R:       if (pull_rvalid) state_nx = (pull_rresp == 2'b00) ? DRAIN : IDLE;
      DRAIN:   if (advance && idx == 4'd15) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge axi4_mm_clk) begin
    if (axi4_mm_rst) begin
      state         <= IDLE;
      ring_rd_count <= '0;
      stale_cnt     <= '0;
      rd_err_cnt    <= '0;
      line_buf      <= '0;
      idx           <= '0;
      pull_araddr   <= '0;
      pull_aruser   <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (ring_base == '0) begin
            ring_rd_count <= '0;
            stale_cnt     <= '0;
            rd_err_cnt    <= '0;
          end else if (have_work) begin
            pull_araddr <= ring_base + line_off;
            pull_aruser <= csr_aruser;
          end
        end
        R: begin
          if (pull_rvalid) begin
            if (pull_rresp == 2'b00) begin
              line_buf <= pull_rdata;
              idx      <= '0;
            end else begin
              ring_rd_count <= ring_rd_count + 64'd1;
              if (rd_err_cnt != '1) rd_err_cnt <= rd_err_cnt + 16'd1;
            end
          end
        end
        DRAIN: begin
          if (advance) begin
            line_buf <= {32'b0, line_buf[511:32]};
            idx      <= idx + 4'd1;
            if (entry_stale && stale_cnt != '1) stale_cnt <= stale_cnt + 16'd1;
            if (idx == 4'd15) ring_rd_count <= ring_rd_count + 64'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/hot_addr_pull.md
# hot_addr_pull

Consumer end of the hot-address ring protocol. It fetches 64-byte lines from a host-memory circular buffer over an AXI4 read channel and unpacks each line into sixteen 32-bit entries. Each entry is checked against the producer's per-line phase bit, and valid PFNs are emitted one at a time on a valid/ready stream toward the device-side migration engine. It mirrors the producer's framing: 16 entries per line, bit 31 = phase, phase toggles per line, zero entry = empty.

## Interface
Parameters:
- RING_SIZE, 64*1024, ring size in bytes; LINES = RING_SIZE/64 (1024), LB = clog2(LINES)
- ADDR_SIZE, 33, kept for parity with the producer; output PFN width is fixed at 32

Ports:
- axi4_mm_clk  in  1  single clock
- axi4_mm_rst  in  1  reset, synchronous, active-high
- ring_base  in  64  ring byte base address, 64 B aligned; 0 = disabled
- ring_wr_count  in  64  lines published by producer, monotonic
- ring_rd_count  out  64  lines consumed, including skipped and errored lines
- csr_aruser  in  6  driven on aruser
- pull_arid  out  12  constant 0
- pull_araddr  out  64  read address
- pull_aruser  out  6  user bits
- pull_arvalid  out  1  address valid
- pull_arready  in  1  address ready
- pull_rid  in  12  ignored
- pull_rdata  in  512  line data
- pull_rresp  in  2  non-zero = error
- pull_rlast  in  1  ignored (single beat)
- pull_rvalid  in  1  read data valid
- pull_rready  out  1  read data ready
- hot_pfn  out  32  {1'b0, entry[30:0]}
- hot_pfn_valid  out  1  PFN valid
- hot_pfn_ready  in  1  PFN ready
- stale_cnt  out  16  count of discarded phase-mismatch entries, saturating
- rd_err_cnt  out  16  count of lines with rresp != 0, saturating

## Operation
- **Reset:** every output is 0, counters cleared, state IDLE.
- **Entry i of a line:** rdata[32*i +: 32], i = 0..15, consumed in ascending order.
- **Expected phase:** ring_rd_count[0].
- **Read address:** ring_base + {ring_rd_count[LB-1:0], 6'b0}. This is 64-bit modular add; the ring wraps every LINES lines.
- **IDLE**
  - Move to AR when ring_base != 0 and ring_wr_count > ring_rd_count (unsigned).
  - If ring_base == 0, clear ring_rd_count, stale_cnt and rd_err_cnt.
- **AR**
  - pull_arvalid = 1, with araddr and aruser held stable.
  - On arready: latch nothing extra, move to R.
- **R**
  - pull_rready = 1.
  - On rvalid with rresp == 0: capture rdata into the line buffer, set idx = 0, move to DRAIN.
  - On rvalid with rresp != 0: increment rd_err_cnt and ring_rd_count, return to IDLE.
- **DRAIN** (one entry evaluated per cycle)
  - entry == 0: skip, no output.
  - entry[31] != expected phase: skip, increment stale_cnt.
  - Otherwise: assert hot_pfn_valid and hold hot_pfn stable until hot_pfn_ready.
  - Advance idx on a skip or on a handshake.
  - After idx 15 resolves: increment ring_rd_count, return to IDLE.
- **Disabling mid-transaction:** ring_base dropping to 0 in AR, R or DRAIN does not abort the transaction. The FSM completes the AXI transaction and the current line, and the clear happens on the next IDLE cycle. arvalid is never withdrawn before arready.
- **Reset mid-operation:** returns to IDLE immediately and abandons any outstanding AXI transaction. The system resets the interconnect together with this block.

## Timing
- **Fetch start:** arvalid rises 1 cycle after IDLE sees work (registered state).
- **First PFN:** hot_pfn_valid earliest 1 cycle after the R handshake.
- **Throughput:** with ready held high, 1 entry per cycle.
- **Per-line overhead:** with zero-latency arready/rvalid, minimum 1 (IDLE) + 1 (AR) + 1 (R) + 16 (DRAIN) = 19 cycles per line.
- **Counter update:** ring_rd_count updates in the cycle after the last DRAIN entry or the errored R beat. IDLE re-evaluates using the updated value.
- **Outstanding reads:** at most one AR outstanding, never overlapped with DRAIN.
- **Output validity:** hot_pfn_valid is never asserted outside DRAIN.

## Test plan
- **Basic line:** ring_base=0x1000, ring_wr_count=1, line entries = 0x00000100+i with phase 0, ready=1 -> araddr 0x1000; hot_pfn 0x100..0x10F in order on 16 consecutive cycles; ring_rd_count=1.
- **Backpressure and empty slots:** entries 3 and 7 = 0, ready toggling every cycle -> 14 PFNs in order, each held stable while ready=0; stale_cnt stays 0.
- **Wrap-around:** ring_rd_count preloaded via traffic to 1023, ring_wr_count=1025 -> araddr base+0xFFC0, then base+0x0; expected phase 1 then 0.
- **Stale line:** second line (expected phase 1) with all entries phase 0 -> no PFNs; stale_cnt=16; ring_rd_count=2.
- **Read error:** rresp=2'b10 on the first line -> no PFNs; rd_err_cnt=1; ring_rd_count=1; next AR to base+0x40.
- **Reset and disable:** axi4_mm_rst asserted during DRAIN at idx 5 -> next cycle valid=0, ring_rd_count=0, state IDLE. Separately, ring_base=0 mid-DRAIN -> remaining entries still delivered, then counters clear.
